// File: rtl/handshake_responder_pkg.sv
// -----------------------------------------------------------------------------
// handshake_pkg
// Shared types and defaults for the four-phase req/ack bundled-data responder
// and its synchronizer.
//   responder_state_t   : responder FSM encoding (DRAIN is only reachable when
//                         HANDSHAKE_RESPONDER_TIMEOUT_EN is defined)
//   DEFAULT_FLOP_NUMBER : default synchronizer depth
// -----------------------------------------------------------------------------
package handshake_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      VALID = 2'd1,
      ACK   = 2'd2,
      DRAIN = 2'd3
   } responder_state_t;

   localparam int DEFAULT_FLOP_NUMBER = 3;

endpackage

// File: rtl/handshake_responder_sync.sv
// -----------------------------------------------------------------------------
// level_synchronizer
// FLOP_NUMBER-deep asynchronous-reset synchronizer for a level signal that
// crosses into the clk_i domain. Used for req_i in the responder; the same
// block serves an initiator synchronizing ack.
// Ports:
//   clk_i   in   destination clock
//   rstn_i  in   asynchronous active-low reset (chain clears to 0)
//   d_i     in   asynchronous level input
//   q_o     out  synchronized level (last chain stage)
// When _VIVADO_ is defined the chain carries the ASYNC_REG attribute so the
// flops are packed together and excluded from timing-driven retiming.
// -----------------------------------------------------------------------------
module level_synchronizer
   import handshake_pkg::*;
#(
   parameter int FLOP_NUMBER = DEFAULT_FLOP_NUMBER
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic d_i,
   output logic q_o
);

`ifdef _VIVADO_
   (* ASYNC_REG = "TRUE" *)
`endif
   logic [FLOP_NUMBER-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[FLOP_NUMBER-2:0], d_i};
      end
   end

   assign q_o = sync_q[FLOP_NUMBER-1];

endmodule

// File: rtl/handshake_responder.sv
// -----------------------------------------------------------------------------
// handshake_responder
// Receiving end of a four-phase req/ack bundled-data handshake from a foreign
// clock domain. The request is synchronized, the bundled word is captured once
// the synchronized request is seen in IDLE, and the word is offered to the
// local consumer with valid/ready. ack_o rises only after the consumer has
// taken the word and falls one cycle after the synchronized request drops.
//
// Ports:
//   clk_i      in   local clock
//   rstn_i     in   asynchronous active-low reset
//   req_i      in   asynchronous request level (only used through the sync chain)
//   data_i     in   bundled data, held stable by the initiator while req_i is high
//   ack_o      out  registered acknowledge back to the initiator
//   data_o     out  captured word
//   valid_o    out  data_o valid to the consumer
//   ready_i    in   consumer ready
//   busy_o     out  high whenever the FSM is not in IDLE
//   timeout_o  out  one-cycle pulse when req stays high too long after ack
//
// Local handshake: a word is handed off on a rising clk_i edge where valid_o
// and ready_i are both high; valid_o then drops on that same edge. ready_i
// while valid_o is low is ignored.
//
// Optional feature macro: HANDSHAKE_RESPONDER_TIMEOUT_EN. When defined, a
// counter runs in ACK; if req is still high after TIMEOUT_CYCLES cycles,
// timeout_o pulses, ack_o drops and the FSM parks in DRAIN until req falls.
// Without it timeout_o is tied low and ACK waits for req indefinitely.
// -----------------------------------------------------------------------------
module handshake_responder
   import handshake_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int FLOP_NUMBER    = DEFAULT_FLOP_NUMBER,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  req_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  ack_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  busy_o,
   output logic                  timeout_o
);

   // Elaboration-time parameter sanity checks.
   if (FLOP_NUMBER < 2 || FLOP_NUMBER > 4) begin : g_bad_flop_number
      $error("handshake_responder: FLOP_NUMBER must be in 2..4");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
      $error("handshake_responder: TIMEOUT_CYCLES must be at least 1");
   end

   logic                  req_s;
   responder_state_t      state_q, state_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, ack_q, busy_q;
   logic                  expire;

   level_synchronizer #(
      .FLOP_NUMBER (FLOP_NUMBER)
   ) u_req_sync (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .d_i    (req_i),
      .q_o    (req_s)
   );

`ifdef HANDSHAKE_RESPONDER_TIMEOUT_EN
   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q;

   // cnt_q counts completed cycles in ACK; it is zero on entry, so the
   // TIMEOUT_CYCLES-th ACK cycle is the one that sees CNT_LAST.
   assign expire = (state_q == ACK) && req_s && (cnt_q == CNT_LAST);
   assign cnt_d  = (state_q == ACK) ? cnt_q + 1'b1 : '0;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= expire;
      end
   end

   assign timeout_o = timeout_q;
`else
   assign expire    = 1'b0;
   assign timeout_o = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_s)   state_d = VALID;
         // A request that already fell here is still delivered; ACK then
         // sees req_s low on its first cycle and lasts exactly one cycle.
         VALID:   if (ready_i) state_d = ACK;
         ACK: begin
            if (!req_s) begin
               state_d = IDLE;
            end else if (expire) begin
               state_d = DRAIN;
            end
         end
         // Holds off recapture of a request that never fell after ack.
         DRAIN:   if (!req_s)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // data_i is safe to sample here: req_s lags req_i by the sync depth and
   // the initiator holds data_i for as long as req_i is high.
   assign data_d = ((state_q == IDLE) && req_s) ? data_i : data_q;

   // Outputs are decoded from the next state and registered so they leave
   // the block glitch-free; the async reset clears them immediately.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         data_q  <= '0;
         valid_q <= 1'b0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         valid_q <= (state_d == VALID);
         ack_q   <= (state_d == ACK);
         busy_q  <= (state_d != IDLE);
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign ack_o   = ack_q;
   assign busy_o  = busy_q;

endmodule

// File: tb/tb_handshake_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_handshake_responder
// Self-checking bench for handshake_responder: directed scenarios (reset,
// basic transfer, backpressure, back-to-back, early request drop, reset in
// ACK, timeout or indefinite ACK depending on HANDSHAKE_RESPONDER_TIMEOUT_EN)
// followed by a randomized initiator/consumer run checked against a
// transaction-level model: words queued at request time, popped at handoff,
// and fixed request-to-valid / request-drop-to-ack-fall latencies.
// -----------------------------------------------------------------------------
module tb_handshake_responder;

   localparam int DW     = 32;
   localparam int FLOP   = 3;
   localparam int TO_CYC = 16;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          rstn;
   logic          req;
   logic [DW-1:0] din;
   logic          ack;
   logic [DW-1:0] dout;
   logic          valid;
   logic          ready;
   logic          busy;
   logic          tmo;

   always #5 clk = ~clk;

   handshake_responder #(
      .DATA_WIDTH     (DW),
      .FLOP_NUMBER    (FLOP),
      .TIMEOUT_CYCLES (TO_CYC)
   ) dut (
      .clk_i     (clk),
      .rstn_i    (rstn),
      .req_i     (req),
      .data_i    (din),
      .ack_o     (ack),
      .data_o    (dout),
      .valid_o   (valid),
      .ready_i   (ready),
      .busy_o    (busy),
      .timeout_o (tmo)
   );

   // ---------------- scoreboard state ----------------
   int            n_cmp = 0;
   int            n_err = 0;
   logic [DW-1:0] exp_q[$];

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- driver helpers ----------------
   // Advance n rising edges and land 1ns after the last one, where inputs are
   // driven and outputs sampled.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while (busy !== 1'b0 && k < 200) begin
         step(1);
         k++;
      end
      check_val(tag, busy, 0);
   endtask

   // Global time bound.
   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   logic [DW-1:0] word;
   int            k, nv, na, np;
   logic          prev_v;
   int            t, phase, hold, rise_at, drop_at, sent, got;
   logic          xfer;
   bit            stop;

   initial begin
      rstn  = 1'b0;
      req   = 1'b0;
      din   = '0;
      ready = 1'b0;
      step(3);

      // Reset state
      check_val("rst_ack", ack, 0);
      check_val("rst_valid", valid, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_timeout", tmo, 0);
      check_val("rst_data", dout, 0);
      rstn = 1'b1;
      step(2);

      // Basic transfer, ready held high before valid
      ready = 1'b1;
      din   = 32'hDEADBEEF;
      req   = 1'b1;
      step(FLOP);
      check_val("basic_pre_valid", valid, 0);
      step(1);
      check_val("basic_valid", valid, 1);
      check_val("basic_data", dout, 32'hDEADBEEF);
      check_val("basic_busy", busy, 1);
      check_val("basic_no_ack_yet", ack, 0);
      step(1);
      check_val("basic_ack", ack, 1);
      check_val("basic_valid_drop", valid, 0);
      req = 1'b0;
      step(FLOP);
      check_val("basic_ack_hold", ack, 1);
      step(1);
      check_val("basic_ack_fall", ack, 0);
      check_val("basic_idle", busy, 0);

      // Backpressure: ready low for 10 cycles
      ready = 1'b0;
      word  = $urandom;
      din   = word;
      req   = 1'b1;
      step(FLOP + 1);
      check_val("bp_valid", valid, 1);
      check_val("bp_data", dout, word);
      for (int i = 0; i < 10; i++) begin
         step(1);
         check_val("bp_valid_hold", valid, 1);
         check_val("bp_data_hold", dout, word);
         check_val("bp_no_ack", ack, 0);
      end
      ready = 1'b1;
      step(1);
      check_val("bp_ack", ack, 1);
      check_val("bp_valid_drop", valid, 0);
      req = 1'b0;
      din = ~word;
      wait_idle("bp_idle");
      check_val("bp_no_recapture", dout, word);

      // Back-to-back: initiator reacts to ack immediately
      ready = 1'b1;
      for (int w = 1; w <= 2; w++) begin
         din = DW'(w);
         req = 1'b1;
         step(FLOP + 1);
         check_val("b2b_valid", valid, 1);
         check_val("b2b_data", dout, w);
         k = 0;
         while (ack !== 1'b1 && k < 50) begin
            step(1);
            k++;
         end
         check_val("b2b_ack", ack, 1);
         req = 1'b0;
         k = 0;
         while (ack !== 1'b0 && k < 50) begin
            step(1);
            k++;
            check_val("b2b_no_recap", valid, 0);
         end
         check_val("b2b_ack_fall", ack, 0);
      end
      wait_idle("b2b_idle");

      // Protocol violation: req high for only 3 cycles, consumer stalls
      ready  = 1'b0;
      word   = $urandom;
      din    = word;
      req    = 1'b1;
      step(3);
      req    = 1'b0;
      nv     = 0;
      na     = 0;
      prev_v = 1'b0;
      for (int i = 0; i < 24; i++) begin
         if (i == 12) ready = 1'b1;
         step(1);
         if (valid && !prev_v) nv++;
         prev_v = valid;
         if (valid) check_val("pv_data", dout, word);
         if (ack) na++;
      end
      check_val("pv_valid_count", nv, 1);
      check_val("pv_ack_cycles", na, 1);
      check_val("pv_idle", busy, 0);

      // Reset while in ACK
      ready = 1'b1;
      din   = $urandom;
      req   = 1'b1;
      step(FLOP + 2);
      check_val("rmt_in_ack", ack, 1);
      #2;
      rstn = 1'b0;
      #1;
      check_val("rmt_ack_async", ack, 0);
      check_val("rmt_valid_async", valid, 0);
      check_val("rmt_busy_async", busy, 0);
      check_val("rmt_data_lost", dout, 0);
      req = 1'b0;
      step(2);
      rstn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step(1);
         check_val("rmt_no_valid", valid, 0);
      end
      check_val("rmt_idle", busy, 0);

`ifdef HANDSHAKE_RESPONDER_TIMEOUT_EN
      // Timeout: request stuck high after ack
      ready = 1'b1;
      din   = $urandom;
      req   = 1'b1;
      step(FLOP + 2);
      check_val("to_ack_rise", ack, 1);
      for (int i = 1; i < TO_CYC; i++) begin
         step(1);
         check_val("to_pre_pulse", tmo, 0);
      end
      step(1);
      check_val("to_pulse", tmo, 1);
      check_val("to_ack_drop", ack, 0);
      check_val("to_busy", busy, 1);
      np = 0;
      nv = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (tmo) np++;
         if (valid) nv++;
         check_val("to_drain_busy", busy, 1);
      end
      check_val("to_single_pulse", np, 0);
      check_val("to_no_second_valid", nv, 0);
      req = 1'b0;
      step(FLOP + 1);
      check_val("to_drain_exit", busy, 0);
`else
      // No timeout: ACK waits for req indefinitely
      ready = 1'b1;
      din   = $urandom;
      req   = 1'b1;
      step(FLOP + 2);
      check_val("nto_ack_rise", ack, 1);
      np = 0;
      na = 0;
      for (int i = 0; i < TO_CYC + 8; i++) begin
         step(1);
         if (tmo) np++;
         if (ack) na++;
      end
      check_val("nto_no_pulse", np, 0);
      check_val("nto_ack_held", na, TO_CYC + 8);
      req = 1'b0;
      wait_idle("nto_idle");
`endif

      // Randomized run against the transaction-level model
      t       = 0;
      phase   = 0;
      hold    = 0;
      rise_at = -1;
      drop_at = -1;
      sent    = 0;
      got     = 0;
      xfer    = 1'b0;
      stop    = 1'b0;
      req     = 1'b0;
      ready   = 1'b0;
      exp_q.delete();
      for (int it = 0; it < 3000 && !(stop && phase == 0); it++) begin
         step(1);
         t++;
         stop = (it >= 2500);
         if (xfer) begin
            check_val("rnd_ack_after_xfer", ack, 1);
            check_val("rnd_valid_after_xfer", valid, 0);
         end
         if (rise_at >= 0 && t - rise_at == FLOP) check_val("rnd_lat_early", valid, 0);
         if (rise_at >= 0 && t - rise_at == FLOP + 1) begin
            check_val("rnd_lat_valid", valid, 1);
            rise_at = -1;
         end
         if (drop_at >= 0 && t - drop_at == FLOP) check_val("rnd_ack_hold", ack, 1);
         if (drop_at >= 0 && t - drop_at == FLOP + 1) begin
            check_val("rnd_ack_fall", ack, 0);
            drop_at = -1;
         end
         if (valid && exp_q.size() > 0) check_val("rnd_data_stable", dout, exp_q[0]);

         case (phase)
            0: if (!ack && !stop && $urandom_range(0, 2) == 0) begin
                  word = $urandom;
                  din  = word;
                  exp_q.push_back(word);
                  req     = 1'b1;
                  rise_at = t;
                  hold    = $urandom_range(0, 3);
                  sent++;
                  phase = 1;
               end
            1: if (ack) begin
                  if (hold == 0) begin
                     req     = 1'b0;
                     drop_at = t;
                     phase   = 2;
                  end else begin
                     hold--;
                  end
               end
            default: if (!ack) begin
                  din   = $urandom;
                  phase = 0;
               end
         endcase

         ready = ($urandom_range(0, 3) != 0);
         xfer  = valid && ready;
         if (xfer) begin
            if (exp_q.size() == 0) begin
               check_val("rnd_sb_underflow", exp_q.size(), 1);
            end else begin
               check_val("rnd_sb_data", dout, exp_q.pop_front());
               got++;
            end
         end
      end
      check_val("rnd_quiesced", phase, 0);
      check_val("rnd_count", got, sent);
      check_val("rnd_sb_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
